// File: rtl/sm_run_ctrl_if.sv
// Host/CPU-facing signal bundle for the run/halt/step controller.
// Master is the host+CPU side, slave is sm_run_ctrl.
interface sm_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [31:0]      pc;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic             cpu_en;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [31:0]      retired;

    modport master (
        output cmd_valid, cmd_op, cmd_count, pc, bp_en, bp_addr,
        input  cmd_ready, cpu_en, halted, halt_cause, retired
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, pc, bp_en, bp_addr,
        output cmd_ready, cpu_en, halted, halt_cause, retired
    );
endinterface

// File: rtl/sm_run_ctrl.sv
// Run/halt/step/run-N clock-enable sequencer for the single-cycle core; PC breakpoint under SM_RUN_CTRL_BP_EN.
// Latency: command accepted at edge t -> cpu_en high in the following cycle; breakpoint stops cpu_en combinationally.
// Backpressure: cmd_ready low only during the single STEP cycle; commands other than HALT are dropped while running.
module sm_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sm_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_RUNN} state_t;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_RUNN = 2'b11;

    localparam logic [1:0] CAUSE_CMD    = 2'b00;
    localparam logic [1:0] CAUSE_STEP   = 2'b01;
    localparam logic [1:0] CAUSE_BP     = 2'b10;
    localparam logic [1:0] CAUSE_BUDGET = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic             halted_q, halted_d;
    logic [31:0]      retired_q, retired_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             bp_hit;
    logic             cpu_en;
    logic             cmd_ready;
    logic             cmd_fire;

`ifdef SM_RUN_CTRL_BP_EN
    logic skip_q, skip_d;

    // skip lets a resume execute the instruction sitting at bp_addr
    assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q &&
                    ((state_q == ST_RUN) || (state_q == ST_RUNN));
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        cmd_ready = (state_q != ST_STEP);
        cpu_en    = (state_q != ST_HALT) && !bp_hit;
        cmd_fire  = bus.cmd_valid && cmd_ready;
        state_d   = state_q;
        cause_d   = cause_q;
        rem_d     = rem_q;
        retired_d = retired_q + {31'd0, cpu_en};

        case (state_q)
            ST_HALT: begin
                if (cmd_fire) begin
                    case (bus.cmd_op)
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: state_d = ST_STEP;
                        OP_RUNN: begin
                            if (bus.cmd_count != '0) begin
                                state_d = ST_RUNN;
                                rem_d   = bus.cmd_count;
                            end else begin
                                cause_d = CAUSE_BUDGET;
                            end
                        end
                        default: cause_d = CAUSE_CMD;
                    endcase
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_STEP;
            end
            default: begin
                if (cpu_en && (state_q == ST_RUNN)) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                // breakpoint beats budget expiry, which beats a host HALT
                if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if ((state_q == ST_RUNN) && (rem_q == CNT_W'(1))) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BUDGET;
                end else if (cmd_fire && (bus.cmd_op == OP_HALT)) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CMD;
                end
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

`ifdef SM_RUN_CTRL_BP_EN
    always_comb begin
        skip_d = skip_q;
        if ((state_q == ST_HALT) && ((state_d == ST_RUN) || (state_d == ST_RUNN))) begin
            skip_d = 1'b1;
        end else if (cpu_en) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_HALT;
            cause_q   <= CAUSE_CMD;
            halted_q  <= 1'b1;
            retired_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            rem_q     <= rem_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.cpu_en     = cpu_en;
    assign bus.halted     = halted_q;
    assign bus.halt_cause = cause_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_sm_run_ctrl.sv
// Bench for sm_run_ctrl: a tiny CPU model whose PC loops over 0x00..0x1C, a command table plus corner sequences.
// Expected halt records are queued when a command is issued and popped when the controller halts.
module tb_sm_run_ctrl;
    localparam int CNT_W = 16;
`ifdef SM_RUN_CTRL_BP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_RUNN = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm_run_ctrl_if #(.CNT_W(CNT_W)) bus ();
    sm_run_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        int          cnt;
        logic        bp_en;
        logic [31:0] pc0;
        int          en;
        logic [1:0]  cause;
        logic [31:0] pc_end;
    } vec_t;

    typedef struct {
        int          en;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          en_seen = 0;
    logic [31:0] pc_m = 32'h0;
    logic [31:0] ret_m = 32'h0;
    exp_t        sb[$];
    vec_t        tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: the PC model advances on edges where cpu_en was high.
    task automatic cyc();
        logic en;
        #1 en = bus.cpu_en;
        @(posedge clk);
        #1;
        if (en) begin
            en_seen++;
            pc_m = (pc_m + 32'd4) & 32'h1F;
        end
        bus.pc = pc_m;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_m   = v;
        bus.pc = v;
    endtask

    task automatic expect_push(input int en, input logic [1:0] cause, input logic [31:0] pc);
        exp_t e;
        ret_m  = ret_m + en;
        e.en    = en;
        e.cause = cause;
        e.pc    = pc;
        e.ret   = ret_m;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input int cnt);
        bus.cmd_op    = op;
        bus.cmd_count = CNT_W'(cnt);
        bus.cmd_valid = 1'b1;
        en_seen       = 0;
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        exp_t e;
        int   n = 0;
        while (!bus.halted && n < budget) begin
            cyc();
            n++;
        end
        if (!bus.halted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: halted=0 after %0d cycles, want halted=1", name, budget);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.sb: scoreboard empty, want one pending record", name);
        end else begin
            e = sb.pop_front();
            check({name, ".en_cycles"}, en_seen, e.en);
            check({name, ".cause"}, {30'd0, bus.halt_cause}, {30'd0, e.cause});
            check({name, ".pc"}, pc_m, e.pc);
            check({name, ".retired"}, bus.retired, e.ret);
            check({name, ".cpu_en"}, {31'd0, bus.cpu_en}, 32'd0);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_HALT;
        bus.cmd_count = '0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = 32'h10;
        set_pc(32'h0);

        // reset held for 4 edges
        for (int i = 0; i < 4; i++) cyc();
        check("rst.halted", {31'd0, bus.halted}, 32'd1);
        check("rst.cause", {30'd0, bus.halt_cause}, 32'd0);
        check("rst.retired", bus.retired, 32'd0);
        check("rst.cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check("rst.cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        rst_n = 1'b1;

        //             op                   cnt       bp    pc0     en           cause                       pc_end
        tbl[0] = '{OP_STEP,              0,        1'b0, 32'h00, 1,           2'b01,                      32'h04};
        tbl[1] = '{OP_STEP,              0,        1'b0, 32'h04, 1,           2'b01,                      32'h08};
        tbl[2] = '{OP_STEP,              0,        1'b0, 32'h08, 1,           2'b01,                      32'h0C};
        tbl[3] = '{OP_RUNN,              5,        1'b0, 32'h0C, 5,           2'b11,                      32'h00};
        tbl[4] = '{OP_RUNN,              0,        1'b0, 32'h00, 0,           2'b11,                      32'h00};
        tbl[5] = '{OP_HALT,              0,        1'b0, 32'h00, 0,           2'b00,                      32'h00};
        tbl[6] = '{BP ? OP_RUN : OP_RUNN, 4,       1'b1, 32'h00, 4,           BP ? 2'b10 : 2'b11,         32'h10};
        tbl[7] = '{BP ? OP_RUN : OP_RUNN, 8,       1'b1, 32'h10, 8,           BP ? 2'b10 : 2'b11,         32'h10};
        tbl[8] = '{OP_RUNN,              3,        1'b1, 32'h08, BP ? 2 : 3,  BP ? 2'b10 : 2'b11,         BP ? 32'h10 : 32'h14};
        tbl[9] = '{OP_RUNN,              1,        1'b1, 32'h10, 1,           2'b11,                      32'h14};

        for (int i = 0; i < 10; i++) begin
            bus.bp_en = tbl[i].bp_en;
            set_pc(tbl[i].pc0);
            expect_push(tbl[i].en, tbl[i].cause, tbl[i].pc_end);
            issue(tbl[i].op, tbl[i].cnt);
            if (tbl[i].op == OP_STEP) begin
                check($sformatf("v%0d.step_rdy", i), {31'd0, bus.cmd_ready}, 32'd0);
                check($sformatf("v%0d.step_en", i), {31'd0, bus.cpu_en}, 32'd1);
            end
            wait_halt($sformatf("v%0d", i), 100);
        end

        // RUN_N 4 with a host HALT on the last enabled cycle: budget expiry wins
        bus.bp_en = 1'b0;
        set_pc(32'h0);
        expect_push(4, 2'b11, 32'h10);
        issue(OP_RUNN, 4);
        for (int i = 0; i < 3; i++) cyc();
        bus.cmd_op    = OP_HALT;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        wait_halt("runn_halt", 20);

        // host HALT in the cycle pc hits the breakpoint
        bus.bp_en = 1'b1;
        set_pc(32'h08);
        expect_push(BP ? 2 : 3, BP ? 2'b10 : 2'b00, BP ? 32'h10 : 32'h14);
        issue(OP_RUN, 0);
        cyc();
        cyc();
        bus.cmd_op    = OP_HALT;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        wait_halt("bp_halt", 20);

        // reset in the middle of a free run
        bus.bp_en = 1'b0;
        set_pc(32'h0);
        issue(OP_RUN, 0);
        for (int i = 0; i < 50; i++) cyc();
        check("midrun.running", {31'd0, bus.halted}, 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        ret_m = 32'h0;
        check("midrst.halted", {31'd0, bus.halted}, 32'd1);
        check("midrst.retired", bus.retired, 32'd0);
        check("midrst.cause", {30'd0, bus.halt_cause}, 32'd0);
        check("midrst.cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check("midrst.cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        set_pc(32'h0);
        expect_push(3, 2'b00, 32'h0C);
        issue(OP_RUN, 0);
        check("midrst.run_en", {31'd0, bus.cpu_en}, 32'd1);
        cyc();
        cyc();
        bus.cmd_op    = OP_HALT;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        wait_halt("midrst_run", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
